// File: rtl/newton_pkg.sv
// Shared constants, exponent helper and FSM state type for the Newton/Broyden iteration sequencer.
// Latency: none (definitions only); backpressure: not applicable.
package newton_pkg;

    localparam int W_DEF   = 32;
    localparam int N_DEF   = 3;
    localparam int M_DEF   = 4;

    localparam int         EXP_MSB = 30;
    localparam int         EXP_LSB = 23;
    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GO,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } seq_state_e;

    // Biased exponent of an IEEE-754 single, treated purely as an integer.
    function automatic logic [EXP_MSB-EXP_LSB:0] exp_field(input logic [31:0] word);
        return word[EXP_MSB:EXP_LSB];
    endfunction

endpackage

// File: rtl/newton_iter_seq_if.sv
// Start/result handshake and step-datapath bus of the iteration sequencer.
// Latency: wires only; backpressure: start_ready and result_ready carry it.
interface newton_iter_seq_if
    import newton_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int M        = M_DEF,
    parameter int W        = W_DEF,
    parameter int MAX_ITER = 16
) ();

    localparam int IW = $clog2(MAX_ITER + 1);

    logic               start_valid;
    logic               start_ready;
    logic [N*W-1:0]     x_init;
    logic               busy;

    logic               dp_go;
    logic               dp_first;
    logic [N*W-1:0]     dp_x;
    logic [N*M*W-1:0]   dp_invJ;
    logic [N*W-1:0]     dp_x_next;
    logic [N*M*W-1:0]   dp_invJ_next;
    logic [N*W-1:0]     dp_dx;

    logic               result_valid;
    logic               result_ready;
    logic [N*W-1:0]     result_x;
    logic [IW-1:0]      result_iters;
    logic               result_converged;
    logic               result_diverged;

    modport master (
        input  start_valid, x_init, dp_x_next, dp_invJ_next, dp_dx, result_ready,
        output start_ready, busy, dp_go, dp_first, dp_x, dp_invJ,
               result_valid, result_x, result_iters, result_converged, result_diverged
    );

    modport slave (
        output start_valid, x_init, dp_x_next, dp_invJ_next, dp_dx, result_ready,
        input  start_ready, busy, dp_go, dp_first, dp_x, dp_invJ,
               result_valid, result_x, result_iters, result_converged, result_diverged
    );

endinterface

// File: rtl/newton_iter_seq_step_timer.sv
// Step timer: last_o is high in the STEP_LATENCY-th cycle after the load_i cycle.
// Latency: STEP_LATENCY cycles from load; backpressure: none, a new load restarts the count.
module step_timer #(
    parameter int STEP_LATENCY = 1456
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);

    localparam int CW = $clog2(STEP_LATENCY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = CW'(STEP_LATENCY - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign last_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/newton_iter_seq.sv
// Newton/Broyden iteration sequencer: launches fixed-latency steps, holds x/invJ, stops on converge/diverge/limit.
// Latency: STEP_LATENCY+2 cycles per step; backpressure: result held until result_ready, starts refused while busy.
module newton_iter_seq
    import newton_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int M            = M_DEF,
    parameter int W            = W_DEF,
    parameter int STEP_LATENCY = 1456,
    parameter int MAX_ITER     = 16,
    parameter int TOL_EXP      = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    newton_iter_seq_if.master      bus
);

    localparam int         IW    = $clog2(MAX_ITER + 1);
    localparam logic [7:0] TOL_E = 8'(TOL_EXP);

    seq_state_e         state_q, state_d;
    logic [N*W-1:0]     x_q, x_d;
    logic [N*M*W-1:0]   invj_q, invj_d;
    logic [N*W-1:0]     dx_q, dx_d;
    logic [IW-1:0]      iters_q, iters_d;
    logic               first_q, first_d;
    logic               conv_q, conv_d;
    logic               div_q, div_d;

    logic               timer_load;
    logic               timer_last;
    logic [N-1:0]       inf_vec;
    logic [N-1:0]       tol_vec;
    logic               any_inf;
    logic               all_tol;

    step_timer #(
        .STEP_LATENCY (STEP_LATENCY)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .last_o (timer_last)
    );

    // Zero and denormal components have exponent 0 and therefore pass the tolerance test.
    for (genvar i = 0; i < N; i++) begin : g_exp_chk
        logic [7:0] exp_w;
        assign exp_w      = exp_field(dx_q[i*W +: 32]);
        assign inf_vec[i] = (exp_w == EXP_INF);
        assign tol_vec[i] = (exp_w < TOL_E);
    end

    assign any_inf = |inf_vec;
    assign all_tol = &tol_vec;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        invj_d     = invj_q;
        dx_d       = dx_q;
        iters_d    = iters_q;
        first_d    = first_q;
        conv_d     = conv_q;
        div_d      = div_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    x_d     = bus.x_init;
                    invj_d  = '0;
                    dx_d    = '0;
                    iters_d = '0;
                    first_d = 1'b1;
                    conv_d  = 1'b0;
                    div_d   = 1'b0;
                    state_d = ST_GO;
                end
            end
            ST_GO: begin
                timer_load = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_last) begin
                    x_d     = bus.dp_x_next;
                    invj_d  = bus.dp_invJ_next;
                    dx_d    = bus.dp_dx;
                    iters_d = iters_q + IW'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                first_d = 1'b0;
                if (any_inf) begin
                    div_d   = 1'b1;
                    conv_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (all_tol) begin
                    conv_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (iters_q == IW'(MAX_ITER)) begin
                    conv_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GO;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            invj_q  <= '0;
            dx_q    <= '0;
            iters_q <= '0;
            first_q <= 1'b0;
            conv_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            invj_q  <= invj_d;
            dx_q    <= dx_d;
            iters_q <= iters_d;
            first_q <= first_d;
            conv_q  <= conv_d;
            div_q   <= div_d;
        end
    end

    assign bus.start_ready      = (state_q == ST_IDLE);
    assign bus.busy             = (state_q == ST_GO) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign bus.dp_go            = (state_q == ST_GO);
    assign bus.dp_first         = first_q;
    assign bus.dp_x             = x_q;
    assign bus.dp_invJ          = invj_q;
    assign bus.result_valid     = (state_q == ST_DONE);
    assign bus.result_x         = x_q;
    assign bus.result_iters     = iters_q;
    assign bus.result_converged = conv_q;
    assign bus.result_diverged  = div_q;

endmodule

// File: tb/tb_newton_iter_seq.sv
// Bench for newton_iter_seq with a behavioural fixed-latency step datapath and a result scoreboard.
module tb_newton_iter_seq;

    localparam int N    = 3;
    localparam int M    = 4;
    localparam int W    = 32;
    localparam int L    = 4;
    localparam int MAXI = 3;
    localparam int TOL  = 100;
    localparam logic [31:0] DELTA = 32'h0001_0000;

    typedef struct packed {
        logic [95:0]       x;
        logic [2:0][95:0]  dx;
        int                iters;
        logic              conv;
        logic              div;
    } vec_t;

    typedef struct {
        logic [95:0] x;
        int          iters;
        logic        conv;
        logic        div;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    newton_iter_seq_if #(.N(N), .M(M), .W(W), .MAX_ITER(MAXI)) bus ();

    newton_iter_seq #(
        .N(N), .M(M), .W(W), .STEP_LATENCY(L), .MAX_ITER(MAXI), .TOL_EXP(TOL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [95:0] w3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [95:0] xafter(input logic [95:0] x, input int k);
        logic [95:0] r;
        for (int j = 0; j < N; j++) r[j*32 +: 32] = x[j*32 +: 32] + 32'(k) * DELTA;
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [95:0] x, input logic [95:0] d1, input logic [95:0] d2,
                                   input logic [95:0] d3, input int it, input logic cv, input logic dv);
        vec_t v;
        v.x = x; v.dx[0] = d1; v.dx[1] = d2; v.dx[2] = d3;
        v.iters = it; v.conv = cv; v.div = dv;
        return v;
    endfunction

    // Behavioural datapath: outputs are only meaningful in the STEP_LATENCY-th cycle after dp_go.
    logic [2:0][95:0] cur_dx;
    logic [95:0]      cur_x;
    int               step_q;
    int               lat_q;

    always @(posedge clk) begin
        if (rst || (bus.start_valid && bus.start_ready)) begin
            step_q <= 0;
            lat_q  <= 0;
        end else if (bus.dp_go) begin
            step_q <= step_q + 1;
            lat_q  <= 1;
        end else if (lat_q != 0) begin
            lat_q  <= (lat_q == L) ? 0 : lat_q + 1;
        end
    end

    always_comb begin
        bus.dp_x_next    = {3{32'h7F80_0001}};
        bus.dp_dx        = {3{32'h7F80_0000}};
        bus.dp_invJ_next = '1;
        if (lat_q == L && step_q >= 1 && step_q <= 3) begin
            for (int j = 0; j < N; j++)   bus.dp_x_next[j*W +: W]    = bus.dp_x[j*W +: W] + DELTA;
            for (int j = 0; j < N*M; j++) bus.dp_invJ_next[j*W +: W] = bus.dp_invJ[j*W +: W] + 32'd1;
            bus.dp_dx = cur_dx[step_q-1];
        end
    end

    logic [383:0] mon_ij;
    always @(negedge clk) begin
        if (!rst && bus.dp_go) begin
            for (int j = 0; j < N*M; j++) mon_ij[j*32 +: 32] = 32'(step_q);
            chk("dp_first", bus.dp_first, step_q == 0);
            chk("dp_invJ", bus.dp_invJ, mon_ij);
            chk("dp_x", bus.dp_x, xafter(cur_x, step_q));
        end
    end

    exp_t sbq[$];
    vec_t vecs[7];

    task automatic start_vec(input vec_t v, input bit push);
        exp_t e;
        cur_dx = v.dx;
        cur_x  = v.x;
        @(negedge clk);
        chk("start_ready_idle", bus.start_ready, 1'b1);
        bus.x_init      = v.x;
        bus.start_valid = 1'b1;
        if (push) begin
            e.x = xafter(v.x, v.iters); e.iters = v.iters; e.conv = v.conv; e.div = v.div;
            e.cyc = cyc + 1 + v.iters * (L + 2);
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.x_init      = '0;
    endtask

    task automatic wait_result();
        exp_t e;
        for (int i = 0; i < 200 && !bus.result_valid; i++) @(negedge clk);
        if (!bus.result_valid) begin
            nvec++; nmis++;
            $display("FAIL result_timeout: result_valid got 0 required 1");
            if (sbq.size() > 0) e = sbq.pop_front();
        end else if (sbq.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL unexpected_result: result_valid got 1 with no pending solve");
        end else begin
            e = sbq.pop_front();
            chk("result_x", bus.result_x, e.x);
            chk("result_iters", bus.result_iters, e.iters);
            chk("result_converged", bus.result_converged, e.conv);
            chk("result_diverged", bus.result_diverged, e.div);
            chk("result_latency", cyc, e.cyc);
        end
    endtask

    task automatic accept_result();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("start_ready_after_accept", bus.start_ready, 1'b1);
        chk("result_valid_after_accept", bus.result_valid, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_start_ready", bus.start_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dp_go", bus.dp_go, 1'b0);
        chk("rst_dp_first", bus.dp_first, 1'b0);
        chk("rst_dp_x", bus.dp_x, '0);
        chk("rst_dp_invJ", bus.dp_invJ, '0);
        chk("rst_result_valid", bus.result_valid, 1'b0);
        chk("rst_result_x", bus.result_x, '0);
        chk("rst_result_iters", bus.result_iters, '0);
        chk("rst_result_converged", bus.result_converged, 1'b0);
        chk("rst_result_diverged", bus.result_diverged, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] bp_x;
        bus.start_valid  = 1'b0;
        bus.x_init       = '0;
        bus.result_ready = 1'b0;
        cur_dx = '0;
        cur_x  = '0;

        vecs[0] = mkvec(w3(32'h3F800000, 32'h40000000, 32'h40400000), {3{32'h3F800000}},
                        {3{32'h30000000}}, {3{32'h3F800000}}, 2, 1'b1, 1'b0);
        vecs[1] = mkvec(w3(32'h11111111, 32'h22222222, 32'h33333333), {3{32'h3F800000}},
                        {3{32'h3F800000}}, {3{32'h3F800000}}, 3, 1'b0, 1'b0);
        vecs[2] = mkvec(w3(32'h40A00000, 32'hC0A00000, 32'h00000000), w3(32'h3F800000, 32'h7FC00000, 32'h3F800000),
                        {3{32'h3F800000}}, {3{32'h3F800000}}, 1, 1'b0, 1'b1);
        vecs[3] = mkvec(w3(32'h01020304, 32'h05060708, 32'h090A0B0C), w3(32'h00000000, 32'h80000000, 32'h00000000),
                        {3{32'h3F800000}}, {3{32'h3F800000}}, 1, 1'b1, 1'b0);
        vecs[4] = mkvec(w3(32'hAAAA0000, 32'h5555FFFF, 32'h12340000), w3(32'h32000000, 32'h00000000, 32'h00000000),
                        w3(32'h31FFFFFF, 32'h80400000, 32'h00000000), {3{32'h3F800000}}, 2, 1'b1, 1'b0);
        vecs[5] = mkvec(w3(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF), {3{32'h3F800000}},
                        {3{32'h3F800000}}, w3(32'h00000000, 32'h00000000, 32'hFF800000), 3, 1'b0, 1'b1);
        vecs[6] = mkvec(w3(32'h00000001, 32'h00000002, 32'h00000003), w3(32'h7F800000, 32'h00000000, 32'h00000000),
                        {3{32'h3F800000}}, {3{32'h3F800000}}, 1, 1'b0, 1'b1);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_vec(vecs[i], 1'b1);
            wait_result();
            accept_result();
        end

        // Result backpressure: outputs frozen, a start pulse while DONE must be ignored.
        bp_x = xafter(vecs[0].x, 2);
        start_vec(vecs[0], 1'b1);
        wait_result();
        for (int c = 0; c < 10; c++) begin
            bus.start_valid = (c == 4);
            bus.x_init      = (c == 4) ? vecs[1].x : '0;
            @(negedge clk);
            chk("bp_result_valid", bus.result_valid, 1'b1);
            chk("bp_start_ready", bus.start_ready, 1'b0);
            chk("bp_result_x", bus.result_x, bp_x);
            chk("bp_result_iters", bus.result_iters, 2);
            chk("bp_result_converged", bus.result_converged, 1'b1);
        end
        bus.start_valid = 1'b0;
        bus.x_init      = '0;
        accept_result();
        repeat (20) @(negedge clk);
        chk("bp_ignored_busy", bus.busy, 1'b0);
        chk("bp_ignored_valid", bus.result_valid, 1'b0);
        chk("bp_ignored_dp_x", bus.dp_x, bp_x);

        // Reset during the WAIT of step 2, then the same solve must run cleanly.
        start_vec(vecs[0], 1'b0);
        for (int i = 0; i < 100 && !(step_q == 2 && lat_q == 2); i++) @(negedge clk);
        chk("mid_wait_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        start_vec(vecs[0], 1'b1);
        wait_result();
        accept_result();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
